alu_cmd_sequencer: RTL and testbench

- Front-end stage directly upstream of the 8-bit ALU top (add/sub/Booth multiply/non-restoring divide).
- Accepts ALU commands over a valid/ready interface and buffers them in a small FIFO.
- Issues each command to the ALU as a one-cycle start pulse, holding opcode and operands stable until completion.
- Captures alu_result on alu_done into a registered valid/ready response port, with a timeout watchdog.

---
 rtl/alu_cmd_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Front-end stage for the 8-bit ALU (add / sub / Booth multiply / non-restoring
// divide). Commands arrive over a valid/ready port and are buffered in a small
// FIFO. Each command is handed to the ALU with a one-cycle start pulse while
// its opcode and operands are held stable. The ALU result is captured on
// alu_done (or on a watchdog timeout) into a registered valid/ready response
// port. At most one result is outstanding at any time.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_ready = FIFO not full
//   cmd_op/a/b          opcode (00 add, 01 sub, 10 mul, 11 div) and operands
//   alu_start           one-cycle start pulse to the ALU
//   alu_op_code         held opcode to the ALU
//   alu_operand_A/B     held operands to the ALU
//   alu_result/done     ALU result (div = {remainder, quotient}) and completion
//   rsp_valid/ready     response handshake
//   rsp_op/result       opcode and result of the completed command
//   rsp_err             1 = completion forced by the timeout watchdog
//   rsp_zero            captured result was zero
//   busy                FSM not idle or FIFO not empty
//   fifo_count          FIFO occupancy
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [7:0]               cmd_a,
    input  logic [7:0]               cmd_b,
    output logic                     alu_start,
    output logic [1:0]               alu_op_code,
    output logic [7:0]               alu_operand_A,
    output logic [7:0]               alu_operand_B,
    input  logic [15:0]              alu_result,
    input  logic                     alu_done,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [1:0]               rsp_op,
    output logic [15:0]              rsp_result,
    output logic                     rsp_err,
    output logic                     rsp_zero,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int EW = 18;  // {op, a, b}

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t          state_q,      state_d;
    logic [AW-1:0]   wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,     rd_ptr_d;
    logic [CW-1:0]   count_q,      count_d;
    logic [TW-1:0]   tmo_cnt_q,    tmo_cnt_d;
    logic [1:0]      op_q,         op_d;
    logic [7:0]      opa_q,        opa_d;
    logic [7:0]      opb_q,        opb_d;
    logic            rsp_valid_q,  rsp_valid_d;
    logic [1:0]      rsp_op_q,     rsp_op_d;
    logic [15:0]     rsp_result_q, rsp_result_d;
    logic            rsp_err_q,    rsp_err_d;
    logic            rsp_zero_q,   rsp_zero_d;

    logic            push;
    logic            pop;
    logic [EW-1:0]   head;
    logic [TW-1:0]   tmo_cnt_inc;

    // Command storage. Contents need no reset: occupancy is governed by the
    // pointers and count, and an entry is only read after it was written.
    logic [EW-1:0]   fifo_mem [DEPTH];

    assign cmd_ready = (count_q < CW'(DEPTH));
    assign push      = cmd_valid & cmd_ready;
    assign head      = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        tmo_cnt_d    = tmo_cnt_q;
        tmo_cnt_inc  = tmo_cnt_q + TW'(1);
        op_d         = op_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_op_d     = rsp_op_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        rsp_zero_d   = rsp_zero_q;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // A still-high done must not be mistaken for the next
                // command's completion, hence the alu_done qualifier.
                if ((count_q != '0) && !rsp_valid_q && !alu_done) begin
                    pop     = 1'b1;
                    op_d    = head[17:16];
                    opa_d   = head[15:8];
                    opb_d   = head[7:0];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                tmo_cnt_d = tmo_cnt_inc;
                // The incremented count is compared so that the forced
                // completion becomes visible exactly TIMEOUT_CYCLES cycles
                // after the start pulse. A real done wins over the timeout.
                if (alu_done) begin
                    rsp_valid_d  = 1'b1;
                    rsp_op_d     = op_q;
                    rsp_result_d = alu_result;
                    rsp_err_d    = 1'b0;
                    rsp_zero_d   = (alu_result == 16'h0000);
                    state_d      = ST_DRAIN;
                end else if (tmo_cnt_inc == TW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_d  = 1'b1;
                    rsp_op_d     = op_q;
                    rsp_result_d = alu_result;
                    rsp_err_d    = 1'b1;
                    rsp_zero_d   = (alu_result == 16'h0000);
                    state_d      = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!alu_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tmo_cnt_q    <= '0;
            op_q         <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_op_q     <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tmo_cnt_q    <= tmo_cnt_d;
            op_q         <= op_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_op_q     <= rsp_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign alu_start     = (state_q == ST_ISSUE);
    assign alu_op_code   = op_q;
    assign alu_operand_A = opa_q;
    assign alu_operand_B = opb_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_op        = rsp_op_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_zero      = rsp_zero_q;
    assign busy          = (state_q != ST_IDLE) || (count_q != '0);
    assign fifo_count    = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//
// Directed bench for alu_cmd_sequencer. A behavioural ALU stub answers each
// start pulse after a programmable latency, can hold done high for several
// cycles, or can stay silent to exercise the timeout. Expected results are
// hand-computed constants in the step sequence.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        alu_start;
    logic [1:0]  alu_op_code;
    logic [7:0]  alu_operand_A;
    logic [7:0]  alu_operand_B;
    logic [15:0] alu_result;
    logic        alu_done;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_op;
    logic [15:0] rsp_result;
    logic        rsp_err;
    logic        rsp_zero;
    logic        busy;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    alu_cmd_sequencer #(.DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .alu_start     (alu_start),
        .alu_op_code   (alu_op_code),
        .alu_operand_A (alu_operand_A),
        .alu_operand_B (alu_operand_B),
        .alu_result    (alu_result),
        .alu_done      (alu_done),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_op        (rsp_op),
        .rsp_result    (rsp_result),
        .rsp_err       (rsp_err),
        .rsp_zero      (rsp_zero),
        .busy          (busy),
        .fifo_count    (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ------------------------------------------------------------------
    // ALU stub (all activity on the falling edge)
    // ------------------------------------------------------------------
    int          stub_lat    = 1;
    int          stub_hold   = 1;
    bit          stub_never  = 1'b0;
    logic [15:0] stub_fixed  = 16'h0000;
    int          pend_cnt    = 0;
    int          hold_cnt    = 0;
    bit          active      = 1'b0;
    bit          prev_start  = 1'b0;
    logic [17:0] snap        = '0;
    int          stab_err    = 0;
    int          double_start = 0;
    int          start_in_done = 0;

    function automatic logic [15:0] alu_model(input logic [17:0] cmd);
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        op = cmd[17:16];
        a  = cmd[15:8];
        b  = cmd[7:0];
        case (op)
            2'd0:    return {8'h00, a} + {8'h00, b};
            2'd1:    return {8'h00, a} - {8'h00, b};
            2'd2:    return {8'h00, a} * {8'h00, b};
            default: return (b == 8'h00) ? 16'hFFFF : {a % b, a / b};
        endcase
    endfunction

    initial begin
        alu_done   = 1'b0;
        alu_result = 16'h0000;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend_cnt   = 0;
                hold_cnt   = 0;
                active     = 1'b0;
                prev_start = 1'b0;
                alu_done   = 1'b0;
            end else begin
                if (alu_start && alu_done)   start_in_done++;
                if (alu_start && prev_start) double_start++;
                prev_start = alu_start;
                if (hold_cnt > 0) begin
                    hold_cnt--;
                    if (hold_cnt == 0) alu_done = 1'b0;
                end
                if (pend_cnt > 0) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        alu_result = alu_model(snap);
                        alu_done   = 1'b1;
                        hold_cnt   = stub_hold;
                    end
                end
                if (alu_start) begin
                    snap   = {alu_op_code, alu_operand_A, alu_operand_B};
                    active = 1'b1;
                    if (stub_never) alu_result = stub_fixed;
                    else            pend_cnt   = stub_lat;
                end else if (active) begin
                    if (rsp_valid) active = 1'b0;
                    else if ({alu_op_code, alu_operand_A, alu_operand_B} !== snap) stab_err++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers (all called on a falling edge)
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept", 32'(cmd_ready), 1);
        $display("push op=%0d a=%0d b=%0d", op, a, b);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [1:0] op,
                              input logic [15:0] res, input logic err);
        int n;
        n = 0;
        while (!rsp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"},  32'(rsp_valid), 1);
        chk({tag, "_op"},     32'(rsp_op), 32'(op));
        chk({tag, "_result"}, 32'(rsp_result), 32'(res));
        chk({tag, "_err"},    32'(rsp_err), 32'(err));
        chk({tag, "_zero"},   32'(rsp_zero), 32'(res == 16'h0000));
        $display("rsp %s op=%0d result=%h err=%0b zero=%0b",
                 tag, rsp_op, rsp_result, rsp_err, rsp_zero);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_cleared"}, 32'(rsp_valid), 0);
    endtask

    // ------------------------------------------------------------------
    // Directed steps
    // ------------------------------------------------------------------
    initial begin
        int n;
        int seen;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_a     = 8'd0;
        cmd_b     = 8'd0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_start", 32'(alu_start), 0);
        chk("rst_ops",   32'({alu_op_code, alu_operand_A, alu_operand_B}), 0);
        chk("rst_rsp",   32'({rsp_valid, rsp_op, rsp_result, rsp_err, rsp_zero}), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_busy",  32'(busy), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(cmd_ready), 1);

        // ADD / SUB
        stub_lat = 1;
        push(2'd0, 8'd20, 8'd15);
        push(2'd1, 8'd30, 8'd10);
        expect_rsp("add", 2'd0, 16'h0023, 1'b0);
        expect_rsp("sub", 2'd1, 16'h0014, 1'b0);
        chk("start_one_cycle", 32'(double_start), 0);

        // MUL / DIV with a longer ALU latency
        stub_lat = 6;
        push(2'd2, 8'd7, 8'd6);
        push(2'd3, 8'd200, 8'd13);
        expect_rsp("mul", 2'd2, 16'h002A, 1'b0);
        expect_rsp("div", 2'd3, 16'h050F, 1'b0);
        chk("operands_stable", 32'(stab_err), 0);

        // Backpressure: five accepted, sixth held off
        stub_lat = 1;
        push(2'd0, 8'd1, 8'd2);
        push(2'd1, 8'd9, 8'd4);
        push(2'd2, 8'd3, 8'd5);
        push(2'd3, 8'd17, 8'd5);
        push(2'd0, 8'd100, 8'd1);
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_a     = 8'd12;
        cmd_b     = 8'd12;
        for (int i = 0; i < 4; i++) begin
            chk("bp_ready_low", 32'(cmd_ready), 0);
            chk("bp_count",     32'(fifo_count), 4);
            chk("bp_rsp_held",  32'({rsp_valid, rsp_result}), 32'({1'b1, 16'h0003}));
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        expect_rsp("bp1", 2'd0, 16'h0003, 1'b0);
        expect_rsp("bp2", 2'd1, 16'h0005, 1'b0);
        expect_rsp("bp3", 2'd2, 16'h000F, 1'b0);
        expect_rsp("bp4", 2'd3, 16'h0203, 1'b0);
        expect_rsp("bp5", 2'd0, 16'h0065, 1'b0);
        push(2'd2, 8'd12, 8'd12);
        expect_rsp("bp6", 2'd2, 16'h0090, 1'b0);

        // Timeout: stub never completes
        stub_never = 1'b1;
        stub_fixed = 16'h1234;
        push(2'd0, 8'd1, 8'd1);
        n = 0;
        while (!alu_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_start_seen", 32'(alu_start), 1);
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_latency", 32'(n), 64);
        expect_rsp("tmo", 2'd0, 16'h1234, 1'b1);
        stub_never = 1'b0;
        push(2'd1, 8'd9, 8'd2);
        expect_rsp("after_tmo", 2'd1, 16'h0007, 1'b0);

        // Done held high after completion
        stub_lat  = 2;
        stub_hold = 6;
        push(2'd0, 8'd4, 8'd4);
        push(2'd0, 8'd5, 8'd5);
        expect_rsp("stuck1", 2'd0, 16'h0008, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("stuck_no_start", 32'(alu_start), 0);
            chk("stuck_no_rsp",   32'(rsp_valid), 0);
            @(negedge clk);
        end
        expect_rsp("stuck2", 2'd0, 16'h000A, 1'b0);
        chk("no_start_while_done", 32'(start_in_done), 0);
        stub_hold = 1;
        repeat (10) @(negedge clk);

        // Reset in the middle of WAIT with three commands queued
        stub_never = 1'b1;
        stub_fixed = 16'h00FF;
        push(2'd0, 8'd11, 8'd22);
        push(2'd1, 8'd33, 8'd44);
        push(2'd2, 8'd55, 8'd66);
        push(2'd3, 8'd77, 8'd88);
        repeat (2) @(negedge clk);
        chk("pre_rst_count", 32'(fifo_count), 3);
        chk("pre_rst_busy",  32'(busy), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_start", 32'(alu_start), 0);
        chk("mid_rst_ops",   32'({alu_op_code, alu_operand_A, alu_operand_B}), 0);
        chk("mid_rst_rsp",   32'({rsp_valid, rsp_op, rsp_result, rsp_err, rsp_zero}), 0);
        chk("mid_rst_count", 32'(fifo_count), 0);
        chk("mid_rst_busy",  32'(busy), 0);
        repeat (2) @(negedge clk);
        reset      = 1'b0;
        stub_never = 1'b0;
        stub_lat   = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid || alu_start) seen++;
            @(negedge clk);
        end
        chk("post_rst_quiet", 32'(seen), 0);
        chk("post_rst_count", 32'(fifo_count), 0);
        push(2'd0, 8'd0, 8'd0);
        expect_rsp("zero", 2'd0, 16'h0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
